// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack: default sizes, push-source
// encodings and the occupancy-counter width helper.
package stack_pkg;

  localparam int STACK_WIDTH = 8;
  localparam int STACK_DEPTH = 16;

  // StackDst encodings
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  // Occupancy counter must represent 0..depth inclusive
  function automatic int sp_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Stack storage: DEPTH x WIDTH array with one synchronous write port and
// one asynchronous read port. Contents are never cleared.
module stack_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Single write port, committed on the rising edge
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// Operand stack for the multicycle stack machine. Decodes push/pop/tos,
// maintains the occupancy count, captures popped/peeked values into a
// holding register and tracks sticky overflow/underflow errors.
module stack_unit
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       tos,
  input  logic                       StackDst,
  input  logic [WIDTH-1:0]           mem_data,
  input  logic [WIDTH-1:0]           alu_data,
  output logic [WIDTH-1:0]           out_q,
  output logic                       zero,
  output logic [sp_width(DEPTH)-1:0] sp,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int SPW = sp_width(DEPTH);
  localparam int AW  = $clog2(DEPTH);

  logic [SPW-1:0]   sp_q, sp_d;
  logic [WIDTH-1:0] out_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] top_data;
  logic [WIDTH-1:0] push_data;
  logic             is_empty, is_full;

  assign is_empty  = (sp_q == '0);
  assign is_full   = (sp_q == SPW'(DEPTH));
  // When empty this wraps to the last entry; it is never consumed then.
  assign top_idx   = AW'(sp_q - SPW'(1));
  assign push_data = (StackDst == SRC_MEM) ? mem_data : alu_data;

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (push_data),
    .raddr (top_idx),
    .rdata (top_data)
  );

  // Operation decode: next count, holding value, error flags and RAM write
  always_comb begin
    sp_d        = sp_q;
    out_d       = out_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    we          = 1'b0;
    waddr       = AW'(sp_q);

    if (pop) begin
      // pop dominates tos
      if (!is_empty) begin
        out_d = top_data;
        if (push) begin
          // replace-top: count unchanged, full does not block
          we    = 1'b1;
          waddr = top_idx;
        end else begin
          sp_d = sp_q - SPW'(1);
        end
      end else begin
        underflow_d = 1'b1;
        if (push) begin
          // empty is never full, so the push always lands in entry 0
          we    = 1'b1;
          waddr = '0;
          sp_d  = SPW'(1);
        end
      end
    end else begin
      if (tos) begin
        if (!is_empty) begin
          out_d = top_data;
        end else begin
          underflow_d = 1'b1;
        end
      end
      if (push) begin
        if (!is_full) begin
          we    = 1'b1;
          waddr = AW'(sp_q);
          sp_d  = sp_q + SPW'(1);
        end else begin
          overflow_d = 1'b1;
        end
      end
    end

    // reset discards any strobe, including the storage write
    if (rst) begin
      we = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q        <= '0;
      out_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      out_q       <= out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign sp        = sp_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign zero      = (out_q == '0);
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: stimulus queues hand-computed expected
// state, a monitor pops and compares one cycle after each marked operation.
module tb_stack_unit;

  localparam int W   = 8;
  localparam int D   = 16;
  localparam int SPW = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           push = 1'b0;
  logic           pop = 1'b0;
  logic           tos = 1'b0;
  logic           StackDst = 1'b0;
  logic [W-1:0]   mem_data = '0;
  logic [W-1:0]   alu_data = '0;
  logic [W-1:0]   out_q;
  logic           zero;
  logic [SPW-1:0] sp;
  logic           empty;
  logic           full;
  logic           overflow;
  logic           underflow;

  always #5 clk = ~clk;

  stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .tos       (tos),
    .StackDst  (StackDst),
    .mem_data  (mem_data),
    .alu_data  (alu_data),
    .out_q     (out_q),
    .zero      (zero),
    .sp        (sp),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // expected flags packed as {empty, full, zero, overflow, underflow}
  typedef struct {
    string          nm;
    logic [W-1:0]   o;
    logic [SPW-1:0] s;
    logic [4:0]     f;
  } exp_t;

  exp_t q[$];
  logic mark   = 1'b0;
  logic mark_d = 1'b0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  always @(posedge clk) mark_d <= mark;

  // monitor: results of a marked operation are visible after the next edge
  always @(negedge clk) begin : mon
    exp_t       e;
    logic [4:0] fl;
    if (mark_d) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL orphan: output marked but no expectation queued");
      end else begin
        e  = q.pop_front();
        fl = {empty, full, zero, overflow, underflow};
        n_cmp++;
        if (out_q !== e.o) begin
          n_bad++;
          $display("FAIL %s out_q: got %02h want %02h", e.nm, out_q, e.o);
        end
        n_cmp++;
        if (sp !== e.s) begin
          n_bad++;
          $display("FAIL %s sp: got %0d want %0d", e.nm, sp, e.s);
        end
        n_cmp++;
        if (fl !== e.f) begin
          n_bad++;
          $display("FAIL %s flags{e,f,z,ov,un}: got %05b want %05b", e.nm, fl, e.f);
        end
      end
    end
  end

  // one cycle of stimulus; when chk is set the expected post-edge state is queued
  task automatic op(input logic r, input logic pu, input logic po, input logic to,
                    input logic dst, input logic [W-1:0] d, input bit chk,
                    input string nm, input logic [W-1:0] eo,
                    input logic [SPW-1:0] es, input logic [4:0] ef);
    exp_t e;
    @(posedge clk);
    #1;
    rst      = r;
    push     = pu;
    pop      = po;
    tos      = to;
    StackDst = dst;
    mem_data = dst ? d : ~d;
    alu_data = dst ? ~d : d;
    mark     = chk;
    if (chk) begin
      e.nm = nm;
      e.o  = eo;
      e.s  = es;
      e.f  = ef;
      q.push_back(e);
    end
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "", 8'h00, 5'd0, 5'b0);
  endtask

  initial begin
    int waited;

    // reset state
    op(1, 0, 0, 0, 0, 8'h00, 1, "reset", 8'h00, 5'd0, 5'b10100);

    // push mem 11,22,33 then pop three times
    op(0, 1, 0, 0, 1, 8'h11, 0, "", 8'h00, 5'd0, 5'b0);
    op(0, 1, 0, 0, 1, 8'h22, 0, "", 8'h00, 5'd0, 5'b0);
    op(0, 1, 0, 0, 1, 8'h33, 1, "push3", 8'h00, 5'd3, 5'b00100);
    op(0, 0, 1, 0, 0, 8'h00, 1, "pop1", 8'h33, 5'd2, 5'b00000);
    op(0, 0, 1, 0, 0, 8'h00, 1, "pop2", 8'h22, 5'd1, 5'b00000);
    op(0, 0, 1, 0, 0, 8'h00, 1, "pop3", 8'h11, 5'd0, 5'b10000);

    // alu push of zero then tos; push 05 then tos
    op(0, 1, 0, 0, 0, 8'h00, 0, "", 8'h00, 5'd0, 5'b0);
    op(0, 0, 0, 1, 0, 8'h00, 1, "tos_zero", 8'h00, 5'd1, 5'b00100);
    op(0, 1, 0, 0, 0, 8'h05, 0, "", 8'h00, 5'd0, 5'b0);
    op(0, 0, 0, 1, 0, 8'h00, 1, "tos_05", 8'h05, 5'd2, 5'b00000);

    // fill to DEPTH, then overflow attempt
    op(1, 0, 0, 0, 0, 8'h00, 1, "reset2", 8'h00, 5'd0, 5'b10100);
    for (int i = 0; i < D; i++) begin
      op(0, 1, 0, 0, 1, 8'(8'h40 + i), (i == D - 1), "fill16", 8'h00, 5'd16, 5'b01100);
    end
    op(0, 1, 0, 0, 1, 8'hAA, 1, "push_full", 8'h00, 5'd16, 5'b01110);
    op(0, 0, 1, 0, 0, 8'h00, 1, "pop_after_full", 8'h4F, 5'd15, 5'b00010);
    op(0, 0, 1, 0, 0, 8'h00, 1, "pop_15th", 8'h4E, 5'd14, 5'b00010);

    // underflow from empty, then push/pop keeps sticky flag
    op(1, 0, 0, 0, 0, 8'h00, 1, "reset3", 8'h00, 5'd0, 5'b10100);
    op(0, 0, 1, 0, 0, 8'h00, 1, "pop_empty", 8'h00, 5'd0, 5'b10101);
    op(0, 1, 0, 0, 0, 8'h07, 1, "push_07", 8'h00, 5'd1, 5'b00101);
    op(0, 0, 1, 0, 0, 8'h00, 1, "pop_07", 8'h07, 5'd0, 5'b10001);

    // replace-top: [04,09] push 0D with pop
    op(1, 0, 0, 0, 0, 8'h00, 0, "", 8'h00, 5'd0, 5'b0);
    op(0, 1, 0, 0, 0, 8'h04, 0, "", 8'h00, 5'd0, 5'b0);
    op(0, 1, 0, 0, 0, 8'h09, 1, "push_09", 8'h00, 5'd2, 5'b00100);
    op(0, 1, 1, 0, 0, 8'h0D, 1, "push_pop", 8'h09, 5'd2, 5'b00000);
    op(0, 0, 0, 1, 0, 8'h00, 1, "tos_0D", 8'h0D, 5'd2, 5'b00000);

    // reset wins over a concurrent push at sp=3
    op(0, 1, 0, 0, 1, 8'h01, 1, "push_sp3", 8'h0D, 5'd3, 5'b00000);
    op(1, 1, 0, 0, 1, 8'h55, 1, "rst_push", 8'h00, 5'd0, 5'b10100);

    // push+pop on empty: push lands, underflow set; then tos; then pop+tos acts as pop
    op(0, 1, 1, 0, 1, 8'h3C, 1, "push_pop_empty", 8'h00, 5'd1, 5'b00101);
    op(0, 0, 0, 1, 0, 8'h00, 1, "tos_3C", 8'h3C, 5'd1, 5'b00001);
    op(0, 0, 1, 1, 0, 8'h00, 1, "pop_tos", 8'h3C, 5'd0, 5'b10001);

    // push with tos: captures old top, push proceeds
    op(0, 1, 0, 0, 0, 8'h21, 0, "", 8'h00, 5'd0, 5'b0);
    op(0, 1, 0, 1, 1, 8'h42, 1, "push_tos", 8'h21, 5'd2, 5'b00001);
    op(0, 0, 0, 1, 0, 8'h00, 1, "tos_42", 8'h42, 5'd2, 5'b00001);

    idle();
    waited = 0;
    while ((q.size() != 0 || mark_d) && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware operand stack for the multicycle stack-machine processor, sitting directly downstream of the controller in the datapath. It consumes the controller's `push`, `pop`, `tos` and `StackDst` strobes, stores operands in an internal LIFO and presents the popped or peeked value in a holding register. That register feeds the ALU A-input, the memory write-data path, and the zero flag used by the Jz condition.

## Interface
- `WIDTH`, 8: data word width.
- `DEPTH`, 16: number of stack entries; must be a power of two ≥ 2.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `push`  in  1  push the selected source onto the stack this cycle.
- `pop`  in  1  remove the top entry and capture it into `out_q`.
- `tos`  in  1  capture the top entry into `out_q` without removing it.
- `StackDst`  in  1  push source select: 0 = `alu_data`, 1 = `mem_data`.
- `mem_data`  in  WIDTH  memory read data (PUSH instruction).
- `alu_data`  in  WIDTH  ALU result register (ADD/SUB/AND/NOT write-back).
- `out_q`  out  WIDTH  holding register: last popped or peeked value.
- `zero`  out  1  `out_q == 0`, combinational from `out_q`.
- `sp`  out  $clog2(DEPTH)+1  occupancy count, 0..DEPTH.
- `empty`  out  1  `sp == 0`.
- `full`  out  1  `sp == DEPTH`.
- `overflow`  out  1  sticky: a push was attempted while full.
- `underflow`  out  1  sticky: a pop or tos was attempted while empty.

## Operation
- Storage is `DEPTH` entries. Entry `sp-1` is the top. `sp` counts valid entries.
- Push data is `StackDst ? mem_data : alu_data`, sampled at the clock edge.
- **Push only, not full:** write the data to entry `sp`, then `sp <= sp+1`.
- **Push only, full:** no write and `sp` is unchanged. Set `overflow`.
- **Pop only, not empty:** `out_q <= entry[sp-1]`, then `sp <= sp-1`. The entry contents are left stale.
- **Pop only, empty:** `out_q` and `sp` are unchanged. Set `underflow`.
- **Tos (pop low), not empty:** `out_q <= entry[sp-1]`. `sp` is unchanged.
- **Tos (pop low), empty:** `out_q` is unchanged. Set `underflow`.
- **Pop and tos together:** behaves as pop. `tos` is ignored.
- **Push and pop together, not empty:** replace the top.
  - `out_q <= old entry[sp-1]`.
  - `entry[sp-1] <=` push data.
  - `sp` is unchanged.
  - `full` does not block this case.
- **Push and pop together, empty:** the push executes (`sp` becomes 1) and `out_q` is unchanged. Set `underflow`.
- **Push and tos together, not pop:** `out_q` captures the old top, then the push proceeds under the push-only rules.
- `overflow` and `underflow` clear only on `rst`.
- `zero` tracks `out_q` only, not the live top. It is therefore valid the cycle after a `tos` or `pop`, which matches the controller's Jz sequence (tos state, then branch state).

## Timing
- All state updates happen on the rising edge of `clk`. There are no combinational paths from the strobes to `out_q`.
- Latency from a `pop`/`tos` strobe to new `out_q` is 1 cycle. Latency from `push` to the value being readable by a following `tos` is 1 cycle, so back-to-back push then tos returns the pushed value.
- Reset, when `rst` is high at an edge:
  - `sp = 0`, `out_q = 0`, `overflow = 0`, `underflow = 0`.
  - Consequently `empty = 1`, `full = 0`, `zero = 1`.
  - Entry contents are not cleared.
- Reset asserted during an active strobe: reset wins and the strobe is discarded.
- Strobes are level-sampled once per cycle. A strobe held for N cycles performs N operations. The controller guarantees single-cycle strobes.
- Pointer arithmetic has no wrap-around. `sp` saturates at 0 and at `DEPTH` under the error rules above.

## Structure
- Package `stack_pkg` holds:
  - defaults `STACK_WIDTH = 8` and `STACK_DEPTH = 16`;
  - the `StackDst` encodings `SRC_ALU = 1'b0` and `SRC_MEM = 1'b1`;
  - the `sp` width function.
- Sub-module `stack_ram` holds the storage:
  - `DEPTH x WIDTH`, one synchronous write port;
  - one asynchronous read port addressed by `sp-1`.
- The `stack_unit` top holds:
  - the `sp` counter and its operation-decode logic;
  - the source mux;
  - the `out_q` register;
  - the sticky flags.

## Test plan
- Reset, then push `mem_data` 0x11, 0x22, 0x33 (`StackDst=1`), then pop three times. Required: `out_q` sequence 0x33, 0x22, 0x11; `sp` ends at 0; `empty=1`; no flags set.
- Push `alu_data` 0x00 (`StackDst=0`), then tos. Required: `out_q=0x00`, `zero=1`, `sp=1`. Then push 0x05 and tos. Required: `out_q=0x05`, `zero=0`, `sp=2`.
- Fill to `DEPTH`=16, then push 0xAA. Required: `full=1`, `overflow=1`, `sp=16`. A following pop returns the 16th pushed value, not 0xAA.
- Pop from empty after reset. Required: `underflow=1`, `out_q=0x00`, `sp=0`. Then push 0x07 and pop. Required: `out_q=0x07`, `underflow` still 1.
- With stack [0x04, 0x09] (top 0x09), assert push (`alu_data=0x0D`) and pop in the same cycle. Required: `out_q=0x09`, `sp=2`, and the next tos gives 0x0D.
- With `sp=3`, assert `rst` together with push. Required next cycle: `sp=0`, `out_q=0`, `overflow=0`, `underflow=0`, `empty=1`.
